dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, max consecutive CPU grants while DMA waits (range 1..15).
REQ-002 SHALL have port: clk_i  input  1  clock; the block has one clock.
REQ-003 SHALL have port: reset_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cpu_req_i  input  1  MA stage needs dmem this cycle (load or store).
REQ-005 SHALL have port: cpu_addr_i  input  32  CPU byte address.
REQ-006 SHALL have port: cpu_write_data_i  input  32  CPU lane-replicated store data.
REQ-007 SHALL have port: cpu_write_mask_i  input  4  CPU byte-write enables; 0000 = load.
REQ-008 SHALL have port: cpu_stall_o  output  1  CPU request not granted this cycle.
REQ-009 SHALL have port: dma_valid_i / dma_ready_o  input / output  1 / 1  DMA request handshake.
REQ-010 SHALL have port: dma_addr_i, dma_write_data_i, dma_write_mask_i  input  32, 32, 4  DMA request payload; mask 0000 = read.
REQ-011 SHALL have port: dma_rsp_valid_o, dma_rsp_data_o  output  1, 32  DMA read response.
REQ-012 SHALL have port: dmem_addr_o, dmem_write_data_o, dmem_write_mask_o  output  32, 32, 4  shared memory port.
REQ-013 SHALL have port: dmem_read_data_i  input  32  memory read data, valid one cycle after address.

Function
REQ-014 SHALL grant at most one requester per cycle; grant is combinational from current inputs and state.
REQ-015 SHALL grant CPU when cpu_req_i=1, unless dma_valid_i=1 and starve_cnt==STARVE_LIMIT.
REQ-016 SHALL grant DMA when dma_valid_i=1 and CPU is not granted.
REQ-017 SHALL drive dmem_* from the granted requester; with no grant: addr=cpu_addr_i, data=cpu_write_data_i, mask=0000.
REQ-018 SHALL set dma_ready_o=1 exactly when DMA is granted; the DMA transfer occurs on dma_valid_i & dma_ready_o.
REQ-019 SHALL set cpu_stall_o = cpu_req_i & ~cpu_grant.
REQ-020 SHALL update starve_cnt (4 bits): +1 when dma_valid_i & cpu_grant, saturating at STARVE_LIMIT; cleared to 0 when DMA is granted or dma_valid_i=0.
REQ-021 SHALL register rsp_pending=1 on the cycle a DMA read (mask 0000) is granted, otherwise 0.
REQ-022 SHALL assert dma_rsp_valid_o=rsp_pending with dma_rsp_data_o=dmem_read_data_i (1-cycle latency); DMA responses have no backpressure.
REQ-023 SHALL hold dma_rsp_data_o at 0 when dma_rsp_valid_o=0.
REQ-024 SHALL produce no response for DMA writes; a write completes on its grant cycle.
REQ-025 SHALL support back-to-back DMA reads with one response per cycle.
REQ-026 SHALL NOT route read data to the CPU; the CPU write-back stage samples dmem_read_data_i directly in the cycle after its grant.

Reset
REQ-027 SHALL, while reset_n_i=0, force starve_cnt=0 and rsp_pending=0, giving dma_rsp_valid_o=0 and dma_rsp_data_o=0.
REQ-028 SHALL, during reset, keep grant logic live; it is combinational and unaffected by reset.
REQ-029 SHALL drop any read response still in flight when reset is asserted mid-transfer.

Structure
REQ-030 SHALL place the DMA request bundle typedef (addr, write data, mask) and the DMEM_STARVE_LIMIT default constant in package common.
REQ-031 SHALL be a single flat module with no sub-modules.

Verification
REQ-032 SHALL verify: CPU-only store, addr 0x100, mask 0011 -> dmem mask 0011 the same cycle; cpu_stall_o=0.
REQ-033 SHALL verify: cpu_req_i and dma_valid_i held high continuously, STARVE_LIMIT=4 -> 4 CPU grants, then 1 DMA grant with cpu_stall_o=1, then the pattern repeats.
REQ-034 SHALL verify: DMA-only read of addr 0x40, memory returns 0xDEADBEEF -> dma_rsp_valid_o=1 with data 0xDEADBEEF exactly 1 cycle after the grant.
REQ-035 SHALL verify: three back-to-back DMA reads -> three consecutive responses, in order.
REQ-036 SHALL verify: DMA write with mask 1111 -> no dma_rsp_valid_o pulse.
REQ-037 SHALL verify: reset_n_i asserted the cycle after a DMA read grant -> no response; starve_cnt=0 after release.

Source files
------------

// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common
//   Shared types and constants for the data-memory arbitration slice.
//   - dma_req_t          : one DMA request beat (byte address, store data,
//                          byte-write mask; mask 0000 means read)
//   - DMEM_STARVE_LIMIT  : default number of back-to-back CPU grants allowed
//                          while a DMA request is waiting
//   - DMEM_MASK_READ     : byte mask value that encodes a read access
//   - is_read()          : true when a byte mask encodes a read access
// -----------------------------------------------------------------------------
package common;

    localparam int unsigned DMEM_STARVE_LIMIT = 4;
    localparam int unsigned DMEM_ADDR_W       = 32;
    localparam int unsigned DMEM_DATA_W       = 32;
    localparam int unsigned DMEM_MASK_W       = 4;

    localparam logic [DMEM_MASK_W-1:0] DMEM_MASK_READ = '0;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] write_data;
        logic [DMEM_MASK_W-1:0] write_mask;
    } dma_req_t;

    function automatic logic is_read(input logic [DMEM_MASK_W-1:0] mask);
        return (mask == DMEM_MASK_READ);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the CPU memory-access stage and
//   a DMA engine. The CPU normally wins; a waiting DMA request is guaranteed a
//   slot after STARVE_LIMIT consecutive CPU grants. Grant selection is purely
//   combinational so the memory sees the winning address in the same cycle.
//   DMA reads return data one cycle after their grant; DMA writes complete on
//   the grant cycle and produce no response. CPU read data is not routed here:
//   the CPU write-back stage samples dmem_read_data_i itself.
//
// Ports
//   clk_i              in   1   clock
//   reset_n_i          in   1   asynchronous active-low reset
//   cpu_req_i          in   1   CPU needs the memory this cycle
//   cpu_addr_i         in   32  CPU byte address
//   cpu_write_data_i   in   32  CPU lane-replicated store data
//   cpu_write_mask_i   in   4   CPU byte enables (0000 = load)
//   cpu_stall_o        out  1   CPU request not granted this cycle
//   dma_valid_i        in   1   DMA request valid
//   dma_ready_o        out  1   DMA request accepted this cycle
//   dma_addr_i         in   32  DMA byte address
//   dma_write_data_i   in   32  DMA store data
//   dma_write_mask_i   in   4   DMA byte enables (0000 = read)
//   dma_rsp_valid_o    out  1   DMA read response valid
//   dma_rsp_data_o     out  32  DMA read response data (0 when not valid)
//   dmem_addr_o        out  32  memory address
//   dmem_write_data_o  out  32  memory store data
//   dmem_write_mask_o  out  4   memory byte enables
//   dmem_read_data_i   in   32  memory read data, one cycle after address
// -----------------------------------------------------------------------------
module dmem_arbiter
    import common::*;
#(
    parameter int unsigned STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic                   cpu_req_i,
    input  logic [DMEM_ADDR_W-1:0] cpu_addr_i,
    input  logic [DMEM_DATA_W-1:0] cpu_write_data_i,
    input  logic [DMEM_MASK_W-1:0] cpu_write_mask_i,
    output logic                   cpu_stall_o,

    input  logic                   dma_valid_i,
    output logic                   dma_ready_o,
    input  logic [DMEM_ADDR_W-1:0] dma_addr_i,
    input  logic [DMEM_DATA_W-1:0] dma_write_data_i,
    input  logic [DMEM_MASK_W-1:0] dma_write_mask_i,
    output logic                   dma_rsp_valid_o,
    output logic [DMEM_DATA_W-1:0] dma_rsp_data_o,

    output logic [DMEM_ADDR_W-1:0] dmem_addr_o,
    output logic [DMEM_DATA_W-1:0] dmem_write_data_o,
    output logic [DMEM_MASK_W-1:0] dmem_write_mask_o,
    input  logic [DMEM_DATA_W-1:0] dmem_read_data_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    dma_req_t   dma_req;
    logic       cpu_grant;
    logic       dma_grant;
    logic       dma_starved;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       rsp_pending;

    assign dma_req = '{addr:       dma_addr_i,
                       write_data: dma_write_data_i,
                       write_mask: dma_write_mask_i};

    // Grant decision: deliberately not gated by reset so the memory port keeps
    // serving requests while the sequential state is held cleared.
    assign dma_starved = dma_valid_i & (starve_cnt == LIMIT);
    assign cpu_grant   = cpu_req_i & ~dma_starved;
    assign dma_grant   = dma_valid_i & ~cpu_grant;

    assign cpu_stall_o = cpu_req_i & ~cpu_grant;
    assign dma_ready_o = dma_grant;

    // Memory port mux. With no grant the CPU address/data are still presented
    // but with a zero mask, so the memory performs a harmless read.
    always_comb begin
        dmem_addr_o       = cpu_addr_i;
        dmem_write_data_o = cpu_write_data_i;
        dmem_write_mask_o = DMEM_MASK_READ;
        if (cpu_grant) begin
            dmem_write_mask_o = cpu_write_mask_i;
        end else if (dma_grant) begin
            dmem_addr_o       = dma_req.addr;
            dmem_write_data_o = dma_req.write_data;
            dmem_write_mask_o = dma_req.write_mask;
        end
    end

    // Counts CPU wins while DMA is waiting; any DMA win or an idle DMA side
    // restarts the count, so the guarantee is per waiting request.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!dma_valid_i || dma_grant) begin
            starve_cnt_nxt = '0;
        end else if (cpu_grant && (starve_cnt < LIMIT)) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Response tracking: memory read data arrives one cycle after the address,
    // so a granted DMA read is flagged for exactly the following cycle. An
    // asynchronous reset clears the flag and thereby drops an in-flight reply.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rsp_pending <= 1'b0;
        end else begin
            rsp_pending <= dma_grant & is_read(dma_req.write_mask);
        end
    end

    assign dma_rsp_valid_o = rsp_pending;
    assign dma_rsp_data_o  = rsp_pending ? dmem_read_data_i : '0;

    // Structural invariants of the arbiter.
    a_one_grant : assert property (@(posedge clk_i) !(cpu_grant && dma_grant));
    a_cnt_range : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   starve_cnt <= LIMIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cpu_req_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_write_data_i;
    logic [3:0]  cpu_write_mask_i;
    logic        cpu_stall_o;
    logic        dma_valid_i;
    logic        dma_ready_o;
    logic [31:0] dma_addr_i;
    logic [31:0] dma_write_data_i;
    logic [3:0]  dma_write_mask_i;
    logic        dma_rsp_valid_o;
    logic [31:0] dma_rsp_data_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_write_data_o;
    logic [3:0]  dmem_write_mask_o;
    logic [31:0] dmem_read_data_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .cpu_req_i         (cpu_req_i),
        .cpu_addr_i        (cpu_addr_i),
        .cpu_write_data_i  (cpu_write_data_i),
        .cpu_write_mask_i  (cpu_write_mask_i),
        .cpu_stall_o       (cpu_stall_o),
        .dma_valid_i       (dma_valid_i),
        .dma_ready_o       (dma_ready_o),
        .dma_addr_i        (dma_addr_i),
        .dma_write_data_i  (dma_write_data_i),
        .dma_write_mask_i  (dma_write_mask_i),
        .dma_rsp_valid_o   (dma_rsp_valid_o),
        .dma_rsp_data_o    (dma_rsp_data_o),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_write_data_o (dmem_write_data_o),
        .dmem_write_mask_o (dmem_write_mask_o),
        .dmem_read_data_i  (dmem_read_data_i)
    );

    // Stimulus helper only: applies one cycle's worth of inputs.
    task automatic drive(input logic creq, input logic [31:0] caddr,
                         input logic [31:0] cdata, input logic [3:0] cmask,
                         input logic dval, input logic [31:0] daddr,
                         input logic [31:0] ddata, input logic [3:0] dmask,
                         input logic [31:0] rdata);
        cpu_req_i        = creq;
        cpu_addr_i       = caddr;
        cpu_write_data_i = cdata;
        cpu_write_mask_i = cmask;
        dma_valid_i      = dval;
        dma_addr_i       = daddr;
        dma_write_data_i = ddata;
        dma_write_mask_i = dmask;
        dmem_read_data_i = rdata;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        idle();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D);
        #1;
        n_cmp++;
        if (dma_rsp_valid_o !== 1'b0 || dma_rsp_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rsp: got valid=%b data=%h, want valid=0 data=0",
                     dma_rsp_valid_o, dma_rsp_data_o);
        end
        // Grant logic stays live while reset is held.
        drive(1'b1, 32'h200, 32'h1111_2222, 4'b1111, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++;
        if (cpu_stall_o !== 1'b0 || dmem_write_mask_o !== 4'b1111 || dmem_addr_o !== 32'h200) begin
            n_err++;
            $display("FAIL reset_cpu_grant: got stall=%b mask=%b addr=%h, want 0 1111 00000200",
                     cpu_stall_o, dmem_write_mask_o, dmem_addr_o);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h44, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++;
        if (dma_ready_o !== 1'b1 || dmem_addr_o !== 32'h44) begin
            n_err++;
            $display("FAIL reset_dma_grant: got ready=%b addr=%h, want 1 00000044",
                     dma_ready_o, dmem_addr_o);
        end
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (dma_rsp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_rsp: got valid=%b, want 0", dma_rsp_valid_o);
        end
        @(negedge clk_i);
        idle();
        reset_n_i = 1'b1;
    endtask

    task automatic test_cpu_store();
        @(negedge clk_i);
        drive(1'b1, 32'h100, 32'hA5A5_A5A5, 4'b0011, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++;
        if (dmem_write_mask_o !== 4'b0011 || dmem_addr_o !== 32'h100 ||
            dmem_write_data_o !== 32'hA5A5_A5A5 || cpu_stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_store: got addr=%h data=%h mask=%b stall=%b, want 00000100 a5a5a5a5 0011 0",
                     dmem_addr_o, dmem_write_data_o, dmem_write_mask_o, cpu_stall_o);
        end
        @(negedge clk_i);
        idle();
        #1;
        n_cmp++;
        if (dmem_write_mask_o !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_mask: got %b, want 0000", dmem_write_mask_o);
        end
    endtask

    // Both sides request continuously: expect LIMIT CPU grants then one DMA.
    task automatic test_starvation(input string tag);
        for (int c = 0; c < 3 * (LIMIT + 1); c++) begin
            logic exp_dma;
            @(negedge clk_i);
            drive(1'b1, 32'h300 + 32'(c), 32'h0, 4'b1111, 1'b1, 32'h800, 32'h0, 4'b1111, 32'h0);
            #1;
            exp_dma = ((c % (LIMIT + 1)) == LIMIT);
            n_cmp++;
            if (cpu_stall_o !== exp_dma || dma_ready_o !== exp_dma) begin
                n_err++;
                $display("FAIL %s cycle %0d: got stall=%b ready=%b, want %b %b",
                         tag, c, cpu_stall_o, dma_ready_o, exp_dma, exp_dma);
            end
        end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_dma_read();
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 32'h0, 4'b0000, 32'h0);
        #1;
        n_cmp++;
        if (dma_ready_o !== 1'b1 || dmem_addr_o !== 32'h40 || dma_rsp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL dma_read_grant: got ready=%b addr=%h rsp=%b, want 1 00000040 0",
                     dma_ready_o, dmem_addr_o, dma_rsp_valid_o);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF);
        #1;
        n_cmp++;
        if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL dma_read_rsp: got valid=%b data=%h, want 1 deadbeef",
                     dma_rsp_valid_o, dma_rsp_data_o);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_5678);
        #1;
        n_cmp++;
        if (dma_rsp_valid_o !== 1'b0 || dma_rsp_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL dma_read_after: got valid=%b data=%h, want 0 0",
                     dma_rsp_valid_o, dma_rsp_data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            drive(1'b0, 32'h0, 32'h0, 4'h0, (c < 3), 32'h80 + 32'(4 * c), 32'h0, 4'b0000,
                  (c > 0) ? words[c-1] : 32'h0);
            #1;
            if (c > 0) begin
                n_cmp++;
                if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== words[c-1]) begin
                    n_err++;
                    $display("FAIL b2b_rsp%0d: got valid=%b data=%h, want 1 %h",
                             c - 1, dma_rsp_valid_o, dma_rsp_data_o, words[c-1]);
                end
            end
        end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_dma_write();
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h90, 32'h5555_AAAA, 4'b1111, 32'h0);
        #1;
        n_cmp++;
        if (dma_ready_o !== 1'b1 || dmem_write_mask_o !== 4'b1111 || dmem_write_data_o !== 32'h5555_AAAA) begin
            n_err++;
            $display("FAIL dma_write_grant: got ready=%b mask=%b data=%h, want 1 1111 5555aaaa",
                     dma_ready_o, dmem_write_mask_o, dmem_write_data_o);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h7777_7777);
        #1;
        n_cmp++;
        if (dma_rsp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL dma_write_rsp: got valid=%b, want 0", dma_rsp_valid_o);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA0, 32'h0, 4'b0000, 32'h0);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hBAD0_BAD0);
        #1;
        n_cmp++;
        if (dma_rsp_valid_o !== 1'b0 || dma_rsp_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_rsp: got valid=%b data=%h, want 0 0",
                     dma_rsp_valid_o, dma_rsp_data_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        // Cleared counter shows as a full LIMIT CPU grants before DMA wins.
        test_starvation("post_reset_starve");
    endtask

    // Reference model: counts how many CPU grants in a row DMA has lost.
    task automatic test_random(input int cycles);
        int          waits = 0;
        bit          pend  = 0;
        for (int c = 0; c < cycles; c++) begin
            logic        creq, dval, exp_cpu, exp_dma;
            logic [31:0] caddr, cdata, daddr, ddata, rdata;
            logic [31:0] exp_addr, exp_data;
            logic [3:0]  cmask, dmask, exp_mask;
            creq  = ($urandom_range(0, 3) != 0);
            dval  = ($urandom_range(0, 2) != 0);
            caddr = $urandom; cdata = $urandom; cmask = 4'($urandom);
            daddr = $urandom; ddata = $urandom; rdata = $urandom;
            dmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            @(negedge clk_i);
            drive(creq, caddr, cdata, cmask, dval, daddr, ddata, dmask, rdata);
            #1;
            exp_cpu = creq && !(dval && waits == LIMIT);
            exp_dma = dval && !exp_cpu;
            if (exp_cpu) begin
                exp_addr = caddr; exp_data = cdata; exp_mask = cmask;
            end else if (exp_dma) begin
                exp_addr = daddr; exp_data = ddata; exp_mask = dmask;
            end else begin
                exp_addr = caddr; exp_data = cdata; exp_mask = 4'b0000;
            end
            n_cmp++;
            if (cpu_stall_o !== (creq && !exp_cpu) || dma_ready_o !== exp_dma) begin
                n_err++;
                $display("FAIL rand_grant c%0d: got stall=%b ready=%b, want %b %b",
                         c, cpu_stall_o, dma_ready_o, creq && !exp_cpu, exp_dma);
            end
            n_cmp++;
            if (dmem_addr_o !== exp_addr || dmem_write_data_o !== exp_data || dmem_write_mask_o !== exp_mask) begin
                n_err++;
                $display("FAIL rand_port c%0d: got %h %h %b, want %h %h %b", c,
                         dmem_addr_o, dmem_write_data_o, dmem_write_mask_o,
                         exp_addr, exp_data, exp_mask);
            end
            n_cmp++;
            if (dma_rsp_valid_o !== pend || dma_rsp_data_o !== (pend ? rdata : 32'h0)) begin
                n_err++;
                $display("FAIL rand_rsp c%0d: got %b %h, want %b %h", c,
                         dma_rsp_valid_o, dma_rsp_data_o, pend, pend ? rdata : 32'h0);
            end
            if (!dval || exp_dma) waits = 0;
            else if (exp_cpu && waits < LIMIT) waits++;
            pend = exp_dma && (dmask == 4'b0000);
        end
        @(negedge clk_i);
        idle();
    endtask

    initial begin
        reset_n_i = 1'b0;
        idle();
        test_reset();
        test_cpu_store();
        test_starvation("starve");
        test_dma_read();
        test_back_to_back();
        test_dma_write();
        test_reset_mid_read();
        do_reset();
        test_random(400);
        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
